// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the bit serializer and its holding register.
package serializer_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Width of the down-counter that indexes the bits of one word.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register with a full flag; lets the next word wait
// while the shifter is still emitting the current one.
module ser_hold_reg
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             full_q;
    logic             full_d;

    // Load only happens while empty and drain only while full, so they never collide.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (drain_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on a valid/ready handshake
// and emits them one bit per clock, streaming gaplessly through a one-entry hold.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy
);

    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             sout_q;
    logic             sout_d;
    logic             svalid_q;
    logic             svalid_d;

    logic             hold_full_s;
    logic [WIDTH-1:0] hold_data_s;
    logic             hold_load_s;
    logic             hold_drain_s;
    logic             accept_s;
    logic             last_bit_s;
    logic             to_shift_s;

    // The bit that goes on the line first is always at the head end of the shifter.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    ser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hold_load_s),
        .drain_i (hold_drain_s),
        .data_i  (data_in),
        .data_o  (hold_data_s),
        .full_o  (hold_full_s)
    );

    // Handshake routing: a word bypasses the hold whenever the shifter is free next cycle.
    always_comb begin
        accept_s     = data_valid && !hold_full_s;
        last_bit_s   = (state_q == S_SHIFT) && (cnt_q == '0);
        to_shift_s   = accept_s && ((state_q == S_IDLE) || last_bit_s);
        hold_load_s  = accept_s && !to_shift_s;
        hold_drain_s = last_bit_s && hold_full_s;
    end

    // Next-state for FSM, counter, shifter and registered serial outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        sout_d   = sout_q;
        svalid_d = svalid_q;
        if (hold_drain_s) begin
            state_d  = S_SHIFT;
            cnt_d    = CNT_MAX;
            shift_d  = hold_data_s;
            sout_d   = head_bit(hold_data_s);
            svalid_d = 1'b1;
        end else if (to_shift_s) begin
            state_d  = S_SHIFT;
            cnt_d    = CNT_MAX;
            shift_d  = data_in;
            sout_d   = head_bit(data_in);
            svalid_d = 1'b1;
        end else if (last_bit_s) begin
            // Line drops to 0 when idle so the detector never sees a stale 1.
            state_d  = S_IDLE;
            cnt_d    = '0;
            shift_d  = '0;
            sout_d   = 1'b0;
            svalid_d = 1'b0;
        end else if (state_q == S_SHIFT) begin
            cnt_d    = cnt_q - CW'(1);
            shift_d  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
            sout_d   = head_bit(shift_d);
            svalid_d = 1'b1;
        end else begin
            state_d  = S_IDLE;
            sout_d   = 1'b0;
            svalid_d = 1'b0;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            sout_q   <= 1'b0;
            svalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            sout_q   <= sout_d;
            svalid_q <= svalid_d;
        end
    end

    assign data_ready   = !hold_full_s;
    assign serial_out   = sout_q;
    assign serial_valid = svalid_q;
    assign busy         = (state_q == S_SHIFT) | hold_full_s;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: two serializers (MSB- and LSB-first) share one stimulus stream;
// a negedge monitor compares their lines against per-instance expected bit queues.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b1;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         ready_m, sout_m, sval_m, busy_m;
    logic         ready_l, sout_l, sval_l, busy_l;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit exp_m[$];
    bit exp_l[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_m), .serial_out(sout_m), .serial_valid(sval_m), .busy(busy_m));

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_l), .serial_out(sout_l), .serial_valid(sval_l), .busy(busy_l));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a word becomes W line bits in the configured order.
    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) exp_m.push_back(w[i]);
        for (int i = 0; i < W; i++) exp_l.push_back(w[i]);
    endtask

    // Offer a word until accepted; returns the cycle index of the accepting edge.
    task automatic send_word(input logic [W-1:0] w, output int acc_cyc);
        acc_cyc = -1;
        data_in = w;
        data_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ready_m) begin
                @(posedge clk);
                push_word(w);
                #1;
                acc_cyc = cyc;
                data_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: word %0h never accepted", w);
        data_valid = 1'b0;
    endtask

    // Monitor: line valid iff bits are owed; hold occupied iff more than one word is owed.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_sval_m", sval_m, 0);
            chk("rst_sout_m", sout_m, 0);
            chk("rst_busy_m", busy_m, 0);
            chk("rst_ready_m", ready_m, 1);
            chk("rst_sval_l", sval_l, 0);
            chk("rst_ready_l", ready_l, 1);
        end else begin
            chk("sval_m", sval_m, exp_m.size() != 0);
            chk("busy_m", busy_m, exp_m.size() != 0);
            chk("ready_m", ready_m, exp_m.size() <= W);
            if (exp_m.size() != 0) chk("bit_m", sout_m, exp_m.pop_front());
            else chk("idle_sout_m", sout_m, 0);
            chk("sval_l", sval_l, exp_l.size() != 0);
            chk("busy_l", busy_l, exp_l.size() != 0);
            chk("ready_l", ready_l, exp_l.size() <= W);
            if (exp_l.size() != 0) chk("bit_l", sout_l, exp_l.pop_front());
            else chk("idle_sout_l", sout_l, 0);
        end
    end

    task automatic drain_wait();
        for (int t = 0; t < 200; t++) begin
            if (exp_m.size() == 0 && exp_l.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_m_left", exp_m.size(), 0);
        chk("drain_l_left", exp_l.size(), 0);
        @(posedge clk);
        #1;
    endtask

    int a1, a2, a3;

    initial begin
        // Reset then idle for 10 cycles.
        #15 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_ready", ready_m, 1);
        chk("idle_busy", busy_m, 0);

        // Single word D0 (LSB instance emits 0B-style order of the same bits).
        send_word(8'hD0, a1);
        chk("single_first_bit", sout_m, 1);
        drain_wait();

        // LSB-first 0B gives 1,1,0,1,0,0,0,0 on the LSB instance.
        send_word(8'h0B, a1);
        chk("lsb_first_bit", sout_l, 1);
        drain_wait();

        // Gapless streaming: DD then 0D with valid held.
        send_word(8'hDD, a1);
        send_word(8'h0D, a2);
        chk("gapless_accept_gap", a2 - a1, 1);
        chk("gapless_ready_low", ready_m, 0);
        chk("gapless_busy", busy_m, 1);
        drain_wait();

        // Backpressure: the third word waits for the hold to drain.
        send_word(8'hA5, a1);
        send_word(8'h3C, a2);
        send_word(8'h96, a3);
        chk("bp_second", a2 - a1, 1);
        chk("bp_third", a3 - a1, W + 1);
        drain_wait();

        // Reset mid-word with a word held; valid during reset must be ignored.
        send_word(8'hFF, a1);
        send_word(8'h5A, a2);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_m.delete();
        exp_l.delete();
        #1;
        chk("async_sval", sval_m, 0);
        chk("async_sout", sout_m, 0);
        chk("async_busy", busy_m, 0);
        chk("async_ready", ready_m, 1);
        chk("async_sval_l", sval_l, 0);
        data_in = 8'h77;
        data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        data_valid = 1'b0;
        #2 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_ready", ready_m, 1);
        chk("post_rst_sval", sval_m, 0);

        // Randomized stream with random idle gaps (gap 0 exercises the hold).
        for (int k = 0; k < 40; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send_word(W'($urandom), a1);
        end
        drain_wait();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
